// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential RV32M multiplier: funct3 codes,
// FSM state encoding and operand-signedness decode.
package seq_multiplier_pkg;

  // Width of the M-extension funct3 field.
  localparam int FUNCT_W = 3;

  // Multiply-group funct3 codes; funct[2]=1 selects the divider instead.
  typedef enum logic [FUNCT_W-1:0] {
    F_MUL    = 3'b000,
    F_MULH   = 3'b001,
    F_MULHSU = 3'b010,
    F_MULHU  = 3'b011
  } funct_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  // rs1 is signed for MUL, MULH and MULHSU.
  function automatic logic op1_is_signed(input logic [1:0] f);
    return f != 2'b11;
  endfunction

  // rs2 is signed only for MUL and MULH.
  function automatic logic op2_is_signed(input logic [1:0] f);
    return f[1] == 1'b0;
  endfunction

endpackage

// File: rtl/seq_multiplier_mul_step.sv
// One shift-add step: acc_hi + mcand * mbits, with each partial product
// folded in through an explicit ripple-carry chain.
module mul_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2
) (
  input  logic [WIDTH-1:0]      mcand,
  input  logic [STEP-1:0]       mbits,
  input  logic [WIDTH-1:0]      acc_hi,
  output logic [WIDTH+STEP-1:0] sum
);

  localparam int SW = WIDTH + STEP;

  // Accumulate the STEP shifted partial products bit by bit; the final sum
  // never exceeds (2^WIDTH-1)*2^STEP, so the top carry is always zero.
  always_comb begin
    logic [SW-1:0] total;
    logic [SW-1:0] pp;
    logic          c;
    logic          t;
    // NOTE: every combinational variable gets a value before any branch so
    // no path leaves it unassigned and no latch is inferred.
    total = SW'(acc_hi);
    pp    = '0;
    c     = 1'b0;
    t     = 1'b0;
    for (int j = 0; j < STEP; j++) begin
      pp = mbits[j] ? (SW'(mcand) << j) : '0;
      c  = 1'b0;
      for (int i = 0; i < SW; i++) begin
        t        = total[i];
        total[i] = t ^ pp[i] ^ c;
        c        = (t & pp[i]) | (c & (t ^ pp[i]));
      end
    end
    sum = total;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle RV32M multiplier (MUL/MULH/MULHSU/MULHU). Works on operand
// magnitudes with a STEP-bit shift-add datapath and applies the sign at the end.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 mul_en,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [2*WIDTH-1:0]   result_mul
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = $clog2(N) + 1;

  state_e               state_q, state_d;
  logic [FUNCT_W-1:0]   funct_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 accept;
  logic                 last_step;
  logic                 neg1, neg2;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH+STEP-1:0] step_sum;

  assign accept    = mul_en && !funct[2] && !flush &&
                     (state_q == S_IDLE || state_q == S_DONE);
  assign last_step = (cnt_q == CNT_W'(N - 1));
  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);

  // Operand sign decode and magnitudes; -(2^(WIDTH-1)) maps to itself.
  always_comb begin
    neg1 = op1_is_signed(funct[1:0]) && op1[WIDTH-1];
    neg2 = op2_is_signed(funct[1:0]) && op2[WIDTH-1];
    mag1 = neg1 ? -op1 : op1;
    mag2 = neg2 ? -op2 : op2;
  end

  // Signed-corrected product presented in the FIX cycle.
  assign prod_fix = neg_q ? -acc_q : acc_q;

  mul_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_mul_step (
    .mcand  (mcand_q),
    .mbits  (mplier_q[STEP-1:0]),
    .acc_hi (acc_q[2*WIDTH-1:WIDTH]),
    .sum    (step_sum)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush wins over a new request and aborts CALC/FIX.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_CALC;
      S_CALC: begin
        if (flush)          state_d = S_IDLE;
        else if (last_step) state_d = S_FIX;
      end
      S_FIX:  state_d = flush ? S_IDLE : S_DONE;
      S_DONE: state_d = accept ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latches, shift-add accumulator, step counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct_q    <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result     <= '0;
      result_mul <= '0;
    end else begin
      if (accept) begin
        funct_q  <= funct;
        mcand_q  <= mag1;
        mplier_q <= mag2;
        neg_q    <= neg1 ^ neg2;
        acc_q    <= '0;
        cnt_q    <= '0;
      end
      if (state_q == S_CALC) begin
        acc_q    <= {step_sum, acc_q[WIDTH-1:STEP]};
        mplier_q <= mplier_q >> STEP;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      if (state_q == S_FIX && !flush) begin
        result_mul <= prod_fix;
        result     <= (funct_q == F_MUL) ? prod_fix[WIDTH-1:0]
                                         : prod_fix[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: three instances (STEP=1,2,4) with
// independent start requests; expected results and accept cycles are queued
// on issue and compared when each instance raises done.
module tb_seq_multiplier;
  import seq_multiplier_pkg::*;

  localparam int W = 32;
  localparam int LAT [3] = '{34, 18, 10};

  typedef struct {
    int          acc;
    logic [31:0] res;
    logic [63:0] rm;
    string       tag;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  funct = '0;
  logic        flush = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic        en_v   [3];
  logic        busy_v [3];
  logic        done_v [3];
  logic [31:0] res_v  [3];
  logic [63:0] rm_v   [3];

  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  sb_t sbq [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_multiplier #(.WIDTH(W), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .funct(funct), .mul_en(en_v[0]), .flush(flush),
    .op1(op1), .op2(op2), .busy(busy_v[0]), .done(done_v[0]),
    .result(res_v[0]), .result_mul(rm_v[0]));
  seq_multiplier #(.WIDTH(W), .STEP(2)) u_s2 (
    .clk(clk), .rst(rst), .funct(funct), .mul_en(en_v[1]), .flush(flush),
    .op1(op1), .op2(op2), .busy(busy_v[1]), .done(done_v[1]),
    .result(res_v[1]), .result_mul(rm_v[1]));
  seq_multiplier #(.WIDTH(W), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .funct(funct), .mul_en(en_v[2]), .flush(flush),
    .op1(op1), .op2(op2), .busy(busy_v[2]), .done(done_v[2]),
    .result(res_v[2]), .result_mul(rm_v[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product: sign/zero-extend to 64 bits and multiply.
  function automatic logic [63:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    case (f)
      3'b000, 3'b001: begin sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b}; end
      3'b010:         begin sa = {{32{a[31]}}, a}; sb = {32'h0, b};       end
      default:        begin sa = {32'h0, a};       sb = {32'h0, b};       end
    endcase
    return sa * sb;
  endfunction

  function automatic logic [31:0] pick(input logic [2:0] f, input logic [63:0] p);
    return (f == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  task automatic score(input int k);
    sb_t e;
    if (done_v[k]) begin
      if (sbq[k].size() == 0) begin
        check($sformatf("spurious_done_s%0d", k), 1, 0);
      end else begin
        e = sbq[k].pop_front();
        check($sformatf("%s_lat_s%0d", e.tag, k), 64'(cyc - e.acc), 64'(LAT[k]));
        check($sformatf("%s_res_s%0d", e.tag, k), res_v[k], e.res);
        check($sformatf("%s_rm_s%0d", e.tag, k), rm_v[k], e.rm);
      end
    end
  endtask

  always @(negedge clk) score(0);
  always @(negedge clk) score(1);
  always @(negedge clk) score(2);

  task automatic push(input int k, input int acc, input logic [31:0] er,
                      input logic [63:0] em, input string tag);
    sb_t e;
    e.acc = acc; e.res = er; e.rm = em; e.tag = tag;
    sbq[k].push_back(e);
  endtask

  // Wait for the selected instances to be ready, then pulse mul_en once.
  task automatic issue(input logic [2:0] mask, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [63:0] em,
                       input string tag);
    int guard = 0;
    while (((mask[0] & busy_v[0]) | (mask[1] & busy_v[1]) | (mask[2] & busy_v[2])) && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 200) check({tag, "_ready_timeout"}, 0, 1);
    funct = f; op1 = a; op2 = b;
    for (int k = 0; k < 3; k++) begin
      if (mask[k]) begin
        en_v[k] = 1'b1;
        push(k, cyc, er, em, tag);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) en_v[k] = 1'b0;
  endtask

  task automatic issue_model(input logic [2:0] mask, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input string tag);
    logic [63:0] p;
    p = model(f, a, b);
    issue(mask, f, a, b, pick(f, p), p, tag);
  endtask

  task automatic drain();
    int guard = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && guard < 400) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 400) begin
      check("drain_timeout", 0, 1);
      for (int k = 0; k < 3; k++) sbq[k].delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [31:0] a, b;
    logic [2:0]  f;
    for (int k = 0; k < 3; k++) en_v[k] = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_v[1], 0);
    check("rst_done", done_v[1], 0);
    check("rst_result", res_v[1], 0);
    check("rst_result_mul", rm_v[1], 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Signed vectors on all three step sizes.
    issue(3'b111, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFEB, "mul_7xm3");
    issue(3'b111, 3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 64'h0000_0000_8000_0000, "mulh_min");
    issue(3'b111, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001, "mulhsu_m1");
    issue(3'b111, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 64'hFFFF_FFFE_0000_0001, "mulhu_max");
    issue(3'b111, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 64'h4000_0000_0000_0000, "mulh_minsq");
    issue_model(3'b111, 3'b000, 32'h0, 32'h1234_5678, "mul_zero");
    for (int i = 0; i < 8; i++) begin
      f = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      issue_model(3'b111, f, a, b, $sformatf("rand%0d", i));
    end
    drain();

    // Back-to-back: second MUL held on mul_en through busy, accepted in DONE.
    issue(3'b010, 3'b000, 32'd11, 32'd13, 32'd143, 64'd143, "b2b_first");
    c0 = cyc - 1;
    funct = 3'b000; op1 = 32'd3; op2 = 32'd5; en_v[1] = 1'b1;
    push(1, c0 + LAT[1], 32'd15, 64'd15, "b2b_second");
    while (cyc < c0 + LAT[1] + 1) begin
      @(posedge clk); #1;
    end
    en_v[1] = 1'b0;
    drain();

    // Flush in CALC cycle 5: no done, previous result kept, accept next cycle.
    funct = 3'b000; op1 = 32'd9; op2 = 32'd9; en_v[1] = 1'b1;
    @(posedge clk); #1;
    en_v[1] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("flush_in_calc_busy", busy_v[1], 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle_busy", busy_v[1], 0);
    check("flush_result_held", res_v[1], 32'd15);
    check("flush_result_mul_held", rm_v[1], 64'd15);
    issue(3'b010, 3'b000, 32'd6, 32'd7, 32'd42, 64'd42, "after_flush");
    drain();

    // flush together with mul_en in IDLE is not an accept.
    funct = 3'b000; op1 = 32'd2; op2 = 32'd2; en_v[1] = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    en_v[1] = 1'b0; flush = 1'b0;
    check("flush_en_no_accept", busy_v[1], 0);
    repeat (25) @(posedge clk);
    #1;

    // Divide code is ignored.
    funct = 3'b100; op1 = 32'd4; op2 = 32'd4; en_v[1] = 1'b1;
    @(posedge clk); #1;
    en_v[1] = 1'b0;
    check("div_code_busy", busy_v[1], 0);
    repeat (25) @(posedge clk);
    #1;
    check("div_code_result", res_v[1], 32'd42);

    // Asynchronous reset mid-CALC.
    funct = 3'b000; op1 = 32'd5; op2 = 32'd5; en_v[1] = 1'b1;
    @(posedge clk); #1;
    en_v[1] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", busy_v[1], 1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_busy", busy_v[1], 0);
    check("async_rst_done", done_v[1], 0);
    check("async_rst_result", res_v[1], 0);
    check("async_rst_result_mul", rm_v[1], 0);
    check("async_rst_result_s1", res_v[0], 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    issue_model(3'b111, 3'b001, 32'hFFFF_FFF0, 32'd16, "post_rst_mulh");
    issue_model(3'b111, 3'b000, 32'hFFFF_FFF0, 32'd16, "post_rst_mul");
    drain();

    for (int k = 0; k < 3; k++) check($sformatf("sb_empty_s%0d", k), 64'(sbq[k].size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
